// File: rtl/conv_event_scheduler_if.sv
// Bundle of the event, op-stream and timestep handshakes around the conv event scheduler.
// The slave modport is the scheduler side; master is the surrounding datapath.
interface conv_event_scheduler_if #(
    parameter int KERNEL_SIZE         = 3,
    parameter int IN_CHANNELS         = 2,
    parameter int IMG_WIDTH           = 8,
    parameter int IMG_HEIGHT          = 8,
    parameter int BITS_PER_COORDINATE = 8
);
    localparam int FM_ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int K_ADDR_W  = ($clog2(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS) > 1) ?
                               $clog2(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS) : 1;

    logic                           evt_valid;
    logic                           evt_ready;
    logic                           evt_timestep;
    logic [BITS_PER_COORDINATE-1:0] evt_x;
    logic [BITS_PER_COORDINATE-1:0] evt_y;
    logic [IN_CHANNELS-1:0]         evt_spikes;
    logic                           op_valid;
    logic                           op_ready;
    logic [BITS_PER_COORDINATE-1:0] op_x;
    logic [BITS_PER_COORDINATE-1:0] op_y;
    logic [FM_ADDR_W-1:0]           op_fm_addr;
    logic [K_ADDR_W-1:0]            op_kernel_addr;
    logic                           evt_done;
    logic                           ts_req;
    logic                           ts_done;
    logic                           busy;

    modport master (
        output evt_valid, evt_timestep, evt_x, evt_y, evt_spikes, op_ready, ts_done,
        input  evt_ready, op_valid, op_x, op_y, op_fm_addr, op_kernel_addr,
               evt_done, ts_req, busy
    );

    modport slave (
        input  evt_valid, evt_timestep, evt_x, evt_y, evt_spikes, op_ready, ts_done,
        output evt_ready, op_valid, op_x, op_y, op_fm_addr, op_kernel_addr,
               evt_done, ts_req, busy
    );
endinterface

// File: rtl/conv_event_scheduler.sv
// Walks the kernel window of one input event per spiking channel and issues one update op per
// in-bounds output neuron; timestep markers are held until the op stream drains.
module conv_event_scheduler #(
    parameter int KERNEL_SIZE         = 3,
    parameter int IN_CHANNELS         = 2,
    parameter int IMG_WIDTH           = 8,
    parameter int IMG_HEIGHT          = 8,
    parameter int BITS_PER_COORDINATE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_event_scheduler_if.slave bus
);
    localparam int CW        = BITS_PER_COORDINATE;
    localparam int EW        = BITS_PER_COORDINATE + 2;
    localparam int P         = (KERNEL_SIZE - 1) / 2;
    localparam int FM_ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int K_ADDR_W  = ($clog2(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS) > 1) ?
                               $clog2(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS) : 1;
    localparam int KC_W      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int CH_W      = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam logic [EW-1:0] P_E = EW'(P);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DRAIN   = 2'd2,
        TS_WAIT = 2'd3
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          x_r;
    logic [CW-1:0]          y_r;
    logic [IN_CHANNELS-1:0] spikes_r;
    logic [CH_W-1:0]        ch_r;
    logic [KC_W-1:0]        kr_r;
    logic [KC_W-1:0]        kc_r;
    logic                   ts_r;
    logic                   op_valid_r;
    logic [CW-1:0]          op_x_r;
    logic [CW-1:0]          op_y_r;
    logic [FM_ADDR_W-1:0]   op_fm_addr_r;
    logic [K_ADDR_W-1:0]    op_kernel_addr_r;
    logic                   evt_ready_r;
    logic                   evt_done_r;
    logic                   ts_req_r;
    logic                   busy_r;

    logic [EW-1:0]          ox_s;
    logic [EW-1:0]          oy_s;
    logic                   in_bounds_s;
    logic [FM_ADDR_W-1:0]   fm_addr_s;
    logic [K_ADDR_W-1:0]    kernel_addr_s;
    logic                   ch_spike_s;
    logic                   kc_last_s;
    logic                   kr_last_s;
    logic                   ch_last_s;
    logic                   op_free_s;

    // Output-neuron coordinates and addresses for the current window position.
    always_comb begin
        // Two guard bits: the top bit is the sign of x+P-kc, and x+P never reaches it.
        ox_s          = {2'b00, x_r} + P_E - EW'(kc_r);
        oy_s          = {2'b00, y_r} + P_E - EW'(kr_r);
        in_bounds_s   = !ox_s[EW-1] && !oy_s[EW-1] &&
                        (ox_s < EW'(IMG_WIDTH)) && (oy_s < EW'(IMG_HEIGHT));
        fm_addr_s     = FM_ADDR_W'(oy_s * EW'(IMG_WIDTH) + ox_s);
        kernel_addr_s = K_ADDR_W'((int'(kr_r) * KERNEL_SIZE + int'(kc_r)) * IN_CHANNELS
                                  + int'(ch_r));
        ch_spike_s    = spikes_r[ch_r];
        kc_last_s     = (kc_r == KC_W'(KERNEL_SIZE - 1));
        kr_last_s     = (kr_r == KC_W'(KERNEL_SIZE - 1));
        ch_last_s     = (ch_r == CH_W'(IN_CHANNELS - 1));
        op_free_s     = !op_valid_r || bus.op_ready;
    end

    // Scheduler FSM together with the op register and all registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            x_r              <= {CW{1'b0}};
            y_r              <= {CW{1'b0}};
            spikes_r         <= {IN_CHANNELS{1'b0}};
            ch_r             <= {CH_W{1'b0}};
            kr_r             <= {KC_W{1'b0}};
            kc_r             <= {KC_W{1'b0}};
            ts_r             <= 1'b0;
            op_valid_r       <= 1'b0;
            op_x_r           <= {CW{1'b0}};
            op_y_r           <= {CW{1'b0}};
            op_fm_addr_r     <= {FM_ADDR_W{1'b0}};
            op_kernel_addr_r <= {K_ADDR_W{1'b0}};
            evt_ready_r      <= 1'b1;
            evt_done_r       <= 1'b0;
            ts_req_r         <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            evt_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.evt_valid && evt_ready_r) begin
                        evt_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (bus.evt_timestep) begin
                            ts_r    <= 1'b1;
                            state_r <= DRAIN;
                        end else begin
                            ts_r     <= 1'b0;
                            x_r      <= bus.evt_x;
                            y_r      <= bus.evt_y;
                            spikes_r <= bus.evt_spikes;
                            ch_r     <= {CH_W{1'b0}};
                            kr_r     <= {KC_W{1'b0}};
                            kc_r     <= {KC_W{1'b0}};
                            state_r  <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (op_free_s) begin
                        if (!ch_spike_s) begin
                            // Silent channel: skip its whole window in a single cycle.
                            op_valid_r <= 1'b0;
                            kr_r       <= {KC_W{1'b0}};
                            kc_r       <= {KC_W{1'b0}};
                            if (ch_last_s) begin
                                state_r <= DRAIN;
                            end else begin
                                ch_r <= ch_r + CH_W'(1);
                            end
                        end else begin
                            if (in_bounds_s) begin
                                op_valid_r       <= 1'b1;
                                op_x_r           <= ox_s[CW-1:0];
                                op_y_r           <= oy_s[CW-1:0];
                                op_fm_addr_r     <= fm_addr_s;
                                op_kernel_addr_r <= kernel_addr_s;
                            end else begin
                                op_valid_r <= 1'b0;
                            end
                            if (kc_last_s) begin
                                kc_r <= {KC_W{1'b0}};
                                if (kr_last_s) begin
                                    kr_r <= {KC_W{1'b0}};
                                    if (ch_last_s) begin
                                        state_r <= DRAIN;
                                    end else begin
                                        ch_r <= ch_r + CH_W'(1);
                                    end
                                end else begin
                                    kr_r <= kr_r + KC_W'(1);
                                end
                            end else begin
                                kc_r <= kc_r + KC_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (op_free_s) begin
                        op_valid_r <= 1'b0;
                        if (ts_r) begin
                            ts_req_r <= 1'b1;
                            state_r  <= TS_WAIT;
                        end else begin
                            evt_done_r  <= 1'b1;
                            evt_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                end
                TS_WAIT: begin
                    if (bus.ts_done) begin
                        ts_req_r    <= 1'b0;
                        ts_r        <= 1'b0;
                        evt_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    op_valid_r  <= 1'b0;
                    ts_req_r    <= 1'b0;
                    ts_r        <= 1'b0;
                    evt_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.evt_ready      = evt_ready_r;
    assign bus.op_valid       = op_valid_r;
    assign bus.op_x           = op_x_r;
    assign bus.op_y           = op_y_r;
    assign bus.op_fm_addr     = op_fm_addr_r;
    assign bus.op_kernel_addr = op_kernel_addr_r;
    assign bus.evt_done       = evt_done_r;
    assign bus.ts_req         = ts_req_r;
    assign bus.busy           = busy_r;
endmodule

// File: tb/tb_conv_event_scheduler.sv
// Directed bench for conv_event_scheduler (K=3, 8x8, 2 channels) with hand-derived op lists.
module tb_conv_event_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_event_scheduler_if bus ();

    conv_event_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int done_flag, done_cyc, first_valid, last_acc;
    int stable_err, ready_err, ts_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_op();
        return {bus.op_x, bus.op_y, 8'(bus.op_fm_addr), 8'(bus.op_kernel_addr)};
    endfunction

    function automatic logic [31:0] mk_op(input int ox, input int oy, input int fm, input int k);
        return {8'(ox), 8'(oy), 8'(fm), 8'(k)};
    endfunction

    // Reference op list: kc fastest, then kr, then channel; same padding P=1.
    task automatic build_exp(input int x, input int y, input logic [1:0] sp);
        exp_q.delete();
        for (int ch = 0; ch < 2; ch++) begin
            if (sp[ch]) begin
                for (int kr = 0; kr < 3; kr++) begin
                    for (int kc = 0; kc < 3; kc++) begin
                        int ox, oy;
                        ox = x + 1 - kc;
                        oy = y + 1 - kr;
                        if (ox >= 0 && ox < 8 && oy >= 0 && oy < 8)
                            exp_q.push_back(mk_op(ox, oy, oy * 8 + ox, (kr * 3 + kc) * 2 + ch));
                    end
                end
            end
        end
    endtask

    task automatic compare_ops(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_op%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic send_event(input logic ts, input int x, input int y, input logic [1:0] sp);
        int n;
        n = 0;
        while (!bus.evt_ready && n < 20) begin
            tick();
            n++;
        end
        check("evt_ready_before_send", bus.evt_ready, 1);
        bus.evt_valid    = 1'b1;
        bus.evt_timestep = ts;
        bus.evt_x        = 8'(x);
        bus.evt_y        = 8'(y);
        bus.evt_spikes   = sp;
        tick();
        bus.evt_valid    = 1'b0;
        bus.evt_timestep = 1'b0;
    endtask

    // Collect accepted ops until evt_done; mode 1 drives op_ready as 1-0-0 repeating.
    task automatic run_ops(input int mode, input int max_cycles);
        logic [31:0] cur, prev;
        logic prev_valid, prev_ready;
        got_q.delete();
        done_flag = 0; done_cyc = -1; first_valid = -1; last_acc = -1;
        stable_err = 0; ready_err = 0; ts_err = 0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev = 32'd0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            bus.op_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            cur = pack_op();
            if (prev_valid && !prev_ready && (!bus.op_valid || cur != prev)) stable_err++;
            if (bus.op_valid && first_valid < 0) first_valid = cyc;
            if (bus.op_valid && bus.op_ready) begin
                got_q.push_back(cur);
                last_acc = cyc;
            end
            if (bus.ts_req) ts_err++;
            if (bus.evt_done) begin
                done_flag = 1;
                done_cyc  = cyc;
                break;
            end
            if (bus.evt_ready || !bus.busy) ready_err++;
            prev_valid = bus.op_valid;
            prev_ready = bus.op_ready;
            prev       = cur;
            tick();
        end
        bus.op_ready = 1'b1;
        check("evt_done_seen", done_flag, 1);
    endtask

    task automatic check_done_pulse(input string tag);
        check({tag, "_ready_at_done"}, bus.evt_ready, 1);
        tick();
        check({tag, "_done_one_cycle"}, bus.evt_done, 0);
        check({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        int n, err, acc;
        bus.evt_valid = 1'b0; bus.evt_timestep = 1'b0; bus.evt_x = 8'd0; bus.evt_y = 8'd0;
        bus.evt_spikes = 2'b00; bus.op_ready = 1'b1; bus.ts_done = 1'b0;

        // Reset state
        #1;
        tick(); tick();
        check("rst_evt_ready", bus.evt_ready, 1);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_evt_done", bus.evt_done, 0);
        check("rst_ts_req", bus.ts_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_payload", pack_op(), 0);
        rst = 1'b0;
        tick();

        // Centre event, channel 0 only
        send_event(1'b0, 3, 4, 2'b01);
        run_ops(0, 60);
        build_exp(3, 4, 2'b01);
        compare_ops("centre");
        check("centre_first_valid_cycle", first_valid, 1);
        if (got_q.size() == 9) begin
            check("centre_first", got_q[0], mk_op(4, 5, 44, 0));
            check("centre_last", got_q[8], mk_op(2, 3, 26, 16));
        end else begin
            check("centre_size_for_ends", got_q.size(), 9);
        end
        check("centre_done_after_last", (done_cyc > last_acc) && (done_cyc - last_acc <= 2), 1);
        check("centre_ready_low", ready_err, 0);
        check_done_pulse("centre");

        // Corner event, channel 1 only: hand-computed stream
        send_event(1'b0, 0, 0, 2'b10);
        run_ops(0, 60);
        exp_q.delete();
        exp_q.push_back(mk_op(1, 1, 9, 1));
        exp_q.push_back(mk_op(0, 1, 8, 3));
        exp_q.push_back(mk_op(1, 0, 1, 7));
        exp_q.push_back(mk_op(0, 0, 0, 9));
        compare_ops("corner");
        check_done_pulse("corner");

        // Backpressure with both channels
        send_event(1'b0, 3, 4, 2'b11);
        run_ops(1, 200);
        build_exp(3, 4, 2'b11);
        check("bp_expected_18", exp_q.size(), 18);
        compare_ops("bp");
        check("bp_payload_stable", stable_err, 0);
        check("bp_ready_low", ready_err, 0);
        check_done_pulse("bp");

        // Spike event then timestep marker
        send_event(1'b0, 3, 4, 2'b01);
        run_ops(0, 60);
        check("ts_pre_ops", got_q.size(), 9);
        check("ts_req_during_ops", ts_err, 0);
        check_done_pulse("ts_pre");
        bus.ts_done = 1'b1;
        tick();
        bus.ts_done = 1'b0;
        check("ts_done_ignored_req", bus.ts_req, 0);
        check("ts_done_ignored_ready", bus.evt_ready, 1);
        send_event(1'b1, 0, 0, 2'b00);
        n = 0;
        while (!bus.ts_req && n < 10) begin
            if (bus.op_valid || bus.evt_done) err++;
            tick();
            n++;
        end
        check("ts_req_rise", bus.ts_req, 1);
        err = 0;
        for (int i = 0; i < 5; i++) begin
            if (!bus.ts_req || bus.evt_ready || bus.evt_done || !bus.busy) err++;
            tick();
        end
        bus.ts_done = 1'b1;
        if (!bus.ts_req) err++;
        tick();
        bus.ts_done = 1'b0;
        check("ts_req_held", err, 0);
        check("ts_req_drop", bus.ts_req, 0);
        check("ts_evt_ready", bus.evt_ready, 1);
        check("ts_no_evt_done", bus.evt_done, 0);
        tick();

        // Event with no spikes
        send_event(1'b0, 5, 5, 2'b00);
        run_ops(0, 20);
        check("empty_no_ops", got_q.size(), 0);
        check("empty_no_valid", first_valid < 0, 1);
        check("empty_done_latency", (done_cyc >= 0) && (done_cyc <= 3), 1);
        check_done_pulse("empty");

        // Reset during the stall of the 5th op
        send_event(1'b0, 3, 4, 2'b01);
        acc = 0;
        n = 0;
        while (n < 40) begin
            if (acc == 4 && bus.op_valid) begin
                bus.op_ready = 1'b0;
                break;
            end
            bus.op_ready = 1'b1;
            if (bus.op_valid) acc++;
            tick();
            n++;
        end
        check("rst_mid_reached_op5", acc, 4);
        tick();
        check("rst_mid_stalled", bus.op_valid, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_op_valid", bus.op_valid, 0);
        check("rst_mid_ts_req", bus.ts_req, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_evt_ready", bus.evt_ready, 1);
        check("rst_mid_evt_done", bus.evt_done, 0);
        rst = 1'b0;
        bus.op_ready = 1'b1;
        tick();
        check("rst_mid_no_late_done", bus.evt_done, 0);
        send_event(1'b0, 3, 4, 2'b01);
        run_ops(0, 60);
        build_exp(3, 4, 2'b01);
        compare_ops("post_rst");
        check_done_pulse("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/conv_event_scheduler.md
Name: conv_event_scheduler

Overview:
Sequences the convolution datapath for one input event at a time. Takes captured events (x, y, per-channel spikes, timestep flag) through a valid/ready handshake. For every spiking input channel it walks the KERNEL_SIZE x KERNEL_SIZE window and emits one update op per in-bounds output neuron: feature-map address plus kernel-weight address. The op stream feeds the conv read port of the feature-map arbiter. Timestep events are held until all ops have drained, then handed to the leak/pool stage through a req/done handshake.

Parameters:
KERNEL_SIZE, 3, odd kernel edge length; P = (KERNEL_SIZE-1)/2 ("same" padding)
IN_CHANNELS, 2, input spike channels per event
IMG_WIDTH, 8, feature-map width
IMG_HEIGHT, 8, feature-map height
BITS_PER_COORDINATE, 8, event x/y width
Derived: FM_ADDR_W = clog2(IMG_WIDTH*IMG_HEIGHT); K_ADDR_W = max(1, clog2(KERNEL_SIZE*KERNEL_SIZE*IN_CHANNELS))

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
evt_valid  in  1  event present
evt_ready  out  1  scheduler accepts event (high only in IDLE)
evt_timestep  in  1  event is a timestep marker; spikes/coords ignored
evt_x  in  BITS_PER_COORDINATE  event column
evt_y  in  BITS_PER_COORDINATE  event row
evt_spikes  in  IN_CHANNELS  spike bit per input channel
op_valid  out  1  op register holds an update
op_ready  in  1  downstream accepts op
op_x  out  BITS_PER_COORDINATE  output neuron column
op_y  out  BITS_PER_COORDINATE  output neuron row
op_fm_addr  out  FM_ADDR_W  op_y*IMG_WIDTH + op_x
op_kernel_addr  out  K_ADDR_W  (kr*KERNEL_SIZE + kc)*IN_CHANNELS + ch
evt_done  out  1  one-cycle pulse: spike event fully issued and drained
ts_req  out  1  request timestep processing downstream
ts_done  in  1  downstream timestep processing complete
busy  out  1  state != IDLE or op_valid

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; evt_ready=1 in the following cycle; op_valid=0, evt_done=0, ts_req=0, busy=0. op_x/op_y/op_fm_addr/op_kernel_addr=0. Counters ch, kr, kc =0. Reset mid-scan or mid-timestep discards the event and any pending op; no evt_done is issued.
- States: IDLE, SCAN, DRAIN, TS_WAIT.
- IDLE: evt_ready=1. On evt_valid&evt_ready:
  - evt_timestep=1 -> DRAIN with ts flag set.
  - Otherwise latch x, y, spikes; clear ch/kr/kc; -> SCAN.
- SCAN: one (ch,kr,kc) position evaluated per cycle in which the op register is free: op_valid=0, or op_valid&op_ready this cycle.
  - spikes[ch]=0 -> skip the whole channel in one cycle (ch++, kr=kc=0).
  - Otherwise ox = x+P-kc, oy = y+P-kr, computed signed at BITS_PER_COORDINATE+2 bits.
    - In bounds (0<=ox<IMG_WIDTH, 0<=oy<IMG_HEIGHT) -> load op register, op_valid=1 next cycle.
    - Out of bounds -> no op; the cycle is still consumed.
  - Counter order: kc fastest, then kr, then ch ascending.
  - After the position (IN_CHANNELS-1, K-1, K-1), or a skip of the last channel -> DRAIN.
- Op handshake: payload stable while op_valid&!op_ready. op_valid drops the cycle after acceptance unless a new op is loaded. Sustained throughput is 1 op/cycle with op_ready=1. First op: op_valid=1 in cycle 2 after the acceptance edge, provided the first position is in bounds.
- DRAIN: wait until op_valid=0 (or accepted this cycle).
  - Spike event: pulse evt_done for 1 cycle -> IDLE.
  - Timestep: -> TS_WAIT.
- TS_WAIT: ts_req=1, held until ts_done=1 is sampled. Then ts_req=0 -> IDLE, with no evt_done. ts_done outside TS_WAIT is ignored.
- Spike event with spikes=0: IN_CHANNELS skip cycles, no ops, evt_done pulses.
- evt_valid while not ready: the event is not consumed; the producer holds it.

Test Plan:
- K=3, 8x8, IN_CHANNELS=2. Event (3,4), spikes=01, op_ready=1 -> 9 ops. First: (4,5), fm_addr 44, kernel_addr 0. Last: (2,3), fm_addr 26, kernel_addr 16. evt_done 1 cycle after the last op is accepted.
- Corner event (0,0), spikes=10 -> exactly 4 ops, in order:
  - (1,1) fm_addr 9, kernel_addr 1
  - (0,1) fm_addr 8, kernel_addr 3
  - (1,0) fm_addr 1, kernel_addr 7
  - (0,0) fm_addr 0, kernel_addr 9
- Backpressure: event (3,4), spikes=11, op_ready toggling 1-0-0-1... -> 18 ops, none dropped or duplicated. Payload stable while stalled. evt_ready stays 0 until evt_done.
- Timestep: spike event (3,4), spikes=01, followed by a timestep event -> ts_req rises only after the 9th op is accepted and evt_done. ts_req is held for a 5-cycle ts_done delay, deasserts the cycle after ts_done, then evt_ready=1.
- Event spikes=00 -> no op_valid; evt_done pulses; back to IDLE within 4 cycles.
- rst=1 during the 5th op stall -> next cycle op_valid=0, ts_req=0, busy=0, evt_ready=1, no evt_done. A following event (3,4), spikes=01 yields a normal 9-op stream.
